// File: rtl/ypc_sequencer.sv
// ypc_sequencer
//   Program-counter sequencer for the single-cycle RISC-V datapath.
//   HALT until an entry point is loaded, then RUN sequentially with branch
//   redirection. N prioritised, maskable, level-sensitive interrupts vector
//   into a single (non-nesting) ISR state. The return address is saved in epc
//   and restored by mret. A stall input freezes everything except a load in HALT.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   en               advance enable (0 = stall)
//   load/entry_point load a start address (highest priority)
//   irq/irq_mask     interrupt requests and per-line enables
//   branch_taken/_target  redirect request
//   mret             return from ISR
//   pc, epc          fetch address, saved return address
//   in_isr, irq_id, irq_ack  ISR status, last taken id, one-cycle take pulse
//   retired          count of advanced (en=1, RUN/ISR) cycles
module ypc_sequencer #(
    parameter int          WIDTH      = 32,
    parameter int          NIRQ       = 4,
    parameter logic [31:0] VEC_BASE   = 32'h28,
    parameter int          VEC_STRIDE = 8,
    parameter int          CNT_W      = 32,
    localparam int         IDW        = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] entry_point,
    input  logic [NIRQ-1:0]  irq,
    input  logic [NIRQ-1:0]  irq_mask,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             mret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic             in_isr,
    output logic [IDW-1:0]   irq_id,
    output logic             irq_ack,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] HALT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ISR  = 2'd2;

    logic [1:0]       state;
    logic [NIRQ-1:0]  pend;
    logic             irq_hit;
    logic [IDW-1:0]   irq_sel;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] vec_addr;

    // Lowest pending index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        pend    = irq & irq_mask;
        irq_hit = |pend;
        irq_sel = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pend[i]) irq_sel = IDW'(i);
        end
    end

    assign pc_inc   = pc + WIDTH'(4);
    // Where RUN would go without an interrupt; also the return address on IRQ entry.
    assign seq_pc   = branch_taken ? branch_target : pc_inc;
    assign vec_addr = WIDTH'(VEC_BASE) + WIDTH'(VEC_STRIDE) * WIDTH'(irq_sel);
    assign in_isr   = (state == ISR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= HALT;
            pc      <= '0;
            epc     <= '0;
            irq_id  <= '0;
            irq_ack <= 1'b0;
            retired <= '0;
        end else begin
            irq_ack <= 1'b0;
            case (state)
                HALT: begin
                    // load is honoured regardless of en; nothing else matters here
                    if (load) begin
                        pc    <= entry_point;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        retired <= retired + CNT_W'(1);
                        if (load) begin
                            pc <= entry_point;
                        end else if (irq_hit) begin
                            epc     <= seq_pc;
                            pc      <= vec_addr;
                            irq_id  <= irq_sel;
                            irq_ack <= 1'b1;
                            state   <= ISR;
                        end else begin
                            pc <= seq_pc;
                        end
                    end
                end
                ISR: begin
                    // No nesting: irq is not looked at while in the ISR.
                    if (en) begin
                        retired <= retired + CNT_W'(1);
                        if (load) begin
                            pc    <= entry_point;
                            state <= RUN;
                        end else if (mret) begin
                            pc    <= epc;
                            state <= RUN;
                        end else begin
                            pc <= seq_pc;
                        end
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_ypc_sequencer.sv
// Scoreboard bench for ypc_sequencer. A 32-bit instance covers the main
// behaviour; an 8-bit PC / 4-bit counter instance covers wrap boundaries.
module tb_ypc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, en, load, branch_taken, mret;
    logic [31:0] entry_point, branch_target;
    logic [3:0]  irq, irq_mask;

    logic [31:0] pc, epc, retired;
    logic        in_isr, irq_ack;
    logic [1:0]  irq_id;

    logic [7:0]  s_pc, s_epc;
    logic        s_in_isr, s_irq_ack;
    logic [1:0]  s_irq_id;
    logic [3:0]  s_retired;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit          sel;   // 0 = 32-bit instance, 1 = 8-bit instance
        logic [31:0] pc, epc, id, ret;
        logic        isr, ack;
        string       nm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ypc_sequencer #(.WIDTH(32), .NIRQ(4), .VEC_BASE(32'h28), .VEC_STRIDE(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .entry_point(entry_point),
        .irq(irq), .irq_mask(irq_mask), .branch_taken(branch_taken),
        .branch_target(branch_target), .mret(mret), .pc(pc), .epc(epc),
        .in_isr(in_isr), .irq_id(irq_id), .irq_ack(irq_ack), .retired(retired)
    );

    ypc_sequencer #(.WIDTH(8), .NIRQ(4), .VEC_BASE(32'h28), .VEC_STRIDE(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .entry_point(entry_point[7:0]),
        .irq(irq), .irq_mask(irq_mask), .branch_taken(branch_taken),
        .branch_target(branch_target[7:0]), .mret(mret), .pc(s_pc), .epc(s_epc),
        .in_isr(s_in_isr), .irq_id(s_irq_id), .irq_ack(s_irq_ack), .retired(s_retired)
    );

    task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got 0x%0h required 0x%0h", nm, f, act, exp);
    endtask

    // Monitor: outputs are presented every cycle; compare whatever is queued.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.sel) begin
                cmp(e.nm, "pc", pc, e.pc);
                cmp(e.nm, "epc", epc, e.epc);
                cmp(e.nm, "in_isr", {31'd0, in_isr}, {31'd0, e.isr});
                cmp(e.nm, "irq_id", {30'd0, irq_id}, e.id);
                cmp(e.nm, "irq_ack", {31'd0, irq_ack}, {31'd0, e.ack});
                cmp(e.nm, "retired", retired, e.ret);
            end else begin
                cmp(e.nm, "pc", {24'd0, s_pc}, e.pc);
                cmp(e.nm, "epc", {24'd0, s_epc}, e.epc);
                cmp(e.nm, "in_isr", {31'd0, s_in_isr}, {31'd0, e.isr});
                cmp(e.nm, "irq_id", {30'd0, s_irq_id}, e.id);
                cmp(e.nm, "irq_ack", {31'd0, s_irq_ack}, {31'd0, e.ack});
                cmp(e.nm, "retired", {28'd0, s_retired}, e.ret);
            end
        end
    end

    task automatic set(input bit r, input bit e, input bit l, input logic [31:0] ep,
                       input logic [3:0] iq, input logic [3:0] mk, input bit b,
                       input logic [31:0] bg, input bit m);
        rst_n = r; en = e; load = l; entry_point = ep; irq = iq; irq_mask = mk;
        branch_taken = b; branch_target = bg; mret = m;
    endtask

    // Clock the applied inputs in, then queue what the outputs must be after that edge.
    task automatic ex(input bit sel, input logic [31:0] p, input logic [31:0] ep,
                      input logic isr, input logic [31:0] id, input logic ack,
                      input logic [31:0] ret, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.sel = sel; e.pc = p; e.epc = ep; e.isr = isr; e.id = id;
        e.ack = ack; e.ret = ret; e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex(0, 0, 0, 0, 0, 0, 0, "reset");
        set(1, 1, 0, 0, 4'hF, 4'hF, 1, 32'h100, 1);
        ex(0, 0, 0, 0, 0, 0, 0, "halt_hold");
        set(1, 0, 1, 32'h28, 0, 4'hF, 0, 0, 0);
        ex(0, 32'h28, 0, 0, 0, 0, 0, "halt_load");
        set(1, 1, 0, 0, 0, 4'hF, 0, 0, 0);
        ex(0, 32'h2C, 0, 0, 0, 0, 1, "run1");
        ex(0, 32'h30, 0, 0, 0, 0, 2, "run2");
        // vectored IRQ: lowest of 4'b0110 is line 1 -> 0x28 + 8
        set(1, 1, 0, 0, 4'b0110, 4'hF, 0, 0, 0);
        ex(0, 32'h30, 32'h34, 1, 1, 1, 3, "irq_take");
        ex(0, 32'h34, 32'h34, 1, 1, 0, 4, "isr_step");
        set(1, 1, 0, 0, 0, 4'hF, 0, 0, 1);
        ex(0, 32'h34, 32'h34, 0, 1, 0, 5, "mret");
        set(1, 1, 0, 0, 0, 4'hF, 0, 0, 0);
        ex(0, 32'h38, 32'h34, 0, 1, 0, 6, "run3");
        // masking: line 0 disabled, line 1 taken
        set(1, 1, 0, 0, 4'b0011, 4'b0010, 0, 0, 0);
        ex(0, 32'h30, 32'h3C, 1, 1, 1, 7, "mask_take");
        set(1, 1, 0, 0, 4'b0011, 4'b0010, 0, 0, 1);
        ex(0, 32'h3C, 32'h3C, 0, 1, 0, 8, "mret2");
        // still pending after return, collides with branch -> epc = target
        set(1, 1, 0, 0, 4'b0011, 4'b0010, 1, 32'h100, 0);
        ex(0, 32'h30, 32'h100, 1, 1, 1, 9, "irq_br_col");
        set(1, 1, 0, 0, 4'b0011, 4'b0010, 1, 32'h200, 0);
        ex(0, 32'h200, 32'h100, 1, 1, 0, 10, "isr_branch");
        // stall in ISR with everything asserted
        set(1, 0, 1, 32'h80, 4'hF, 4'hF, 1, 32'h300, 1);
        for (int i = 0; i < 5; i++) ex(0, 32'h200, 32'h100, 1, 1, 0, 10, "stall_isr");
        set(1, 1, 0, 0, 0, 4'hF, 0, 0, 1);
        ex(0, 32'h100, 32'h100, 0, 1, 0, 11, "mret3");
        // stall in RUN with IRQ, branch and load asserted
        set(1, 0, 1, 32'h80, 4'b0001, 4'hF, 1, 32'h300, 1);
        for (int i = 0; i < 5; i++) ex(0, 32'h100, 32'h100, 0, 1, 0, 11, "stall_run");
        set(1, 1, 0, 0, 4'b0001, 4'hF, 0, 0, 0);
        ex(0, 32'h28, 32'h104, 1, 0, 1, 12, "irq0_take");
        set(1, 1, 1, 32'h80, 4'b0001, 4'hF, 0, 0, 1);
        ex(0, 32'h80, 32'h104, 0, 0, 0, 13, "isr_load");
        set(1, 1, 0, 0, 0, 4'hF, 0, 0, 1);
        ex(0, 32'h84, 32'h104, 0, 0, 0, 14, "run_mret_ign");
        set(1, 1, 1, 32'h40, 4'b0001, 4'hF, 1, 32'h300, 0);
        ex(0, 32'h40, 32'h104, 0, 0, 0, 15, "run_load_pri");
        // line 3 -> 0x28 + 24 = 0x40, then reset mid-ISR
        set(1, 1, 0, 0, 4'b1000, 4'b1000, 0, 0, 0);
        ex(0, 32'h40, 32'h44, 1, 3, 1, 16, "irq3_take");
        set(0, 1, 0, 0, 4'b1000, 4'b1000, 0, 0, 0);
        ex(0, 0, 0, 0, 0, 0, 0, "rst_mid_isr");
        set(1, 1, 0, 0, 4'b1000, 4'hF, 1, 32'h300, 1);
        ex(0, 0, 0, 0, 0, 0, 0, "halt_after_rst");
        ex(0, 0, 0, 0, 0, 0, 0, "halt_after_rst2");
        // 8-bit instance: 0xFC + 4 wraps to 0x00, 4-bit counter wraps after 16 steps
        set(1, 0, 1, 32'hFC, 0, 4'hF, 0, 0, 0);
        ex(1, 32'hFC, 0, 0, 0, 0, 0, "s_load");
        set(1, 1, 0, 0, 0, 4'hF, 0, 0, 0);
        for (int k = 1; k <= 16; k++)
            ex(1, (32'hFC + 32'(4 * k)) & 32'hFF, 0, 0, 0, 0, 32'(k % 16), "s_wrap");
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d left required 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
